// File: rtl/cam_capture_pkg.sv
// Shared types and defaults for the OV7670 DVP frame capture stage.
// Optional build macro: CAM_DOWNSCALE_EN (2x2 decimation in cam_frame_capture).
package cam_capture_pkg;

    typedef enum logic [1:0] {
        MODE_RGB565 = 2'd0,
        MODE_RGB444 = 2'd1,
        MODE_YUV    = 2'd2
    } cam_mode_e;

    typedef enum logic [1:0] {
        SYNC,
        FRAME,
        ACTIVE
    } cam_state_e;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_LINE       = 9;
    localparam int DEF_PIXEL      = 10;
    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_V_ACTIVE   = 480;

    // Reserved encoding 3 behaves as RGB565.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        if (m == 2'd3)
            return 2'(MODE_RGB565);
        return m;
    endfunction

endpackage

// File: rtl/cam_pixel_pack.sv
// Combinational packer: camera byte pair plus format to a 4:4:4 pixel.
// Optional build macro: none (CAM_DOWNSCALE_EN lives in the top).
module cam_pixel_pack
    import cam_capture_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [7:0]  hi,
    input  logic [7:0]  lo,
    output logic [11:0] pixel
);

    always_comb begin
        pixel = {hi[7:4], hi[2:0], lo[7], lo[4:1]};
        unique case (1'b1)
            mode == MODE_RGB444: pixel = {hi[3:0], lo[7:4], lo[3:0]};
            // YUV: lo carries Y, U/V in hi are dropped.
            mode == MODE_YUV:    pixel = {3{lo[7:4]}};
            default: ;
        endcase
    end

endmodule

// File: rtl/cam_frame_capture.sv
// OV7670 DVP byte stream to frame-buffer pixel writes with coordinates.
// Optional build macro: CAM_DOWNSCALE_EN (2x2 decimation of writes).
module cam_frame_capture
    import cam_capture_pkg::*;
#(
    parameter int CAM_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CAM_LINE       = DEF_LINE,
    parameter int CAM_PIXEL      = DEF_PIXEL,
    parameter int H_ACTIVE       = DEF_H_ACTIVE,
    parameter int V_ACTIVE       = DEF_V_ACTIVE
) (
    input  logic                      ov7670_pclk,
    input  logic                      reset_n,
    input  logic                      ov7670_vs,
    input  logic                      ov7670_hs,
    input  logic [7:0]                ov7670_data,
    input  logic [1:0]                i_mode,
    output logic                      we,
    output logic [CAM_DATA_WIDTH-1:0] o_data_wr,
    output logic [CAM_LINE-1:0]       o_line,
    output logic [CAM_PIXEL-1:0]      o_pixel,
    output logic                      o_frame_done,
    output logic                      o_line_err
);

    localparam int BW = CAM_PIXEL + 2;
    localparam logic [CAM_PIXEL-1:0] PIX_MAX    = CAM_PIXEL'(H_ACTIVE);
    localparam logic [CAM_LINE-1:0]  LINE_MAX   = CAM_LINE'(V_ACTIVE);
    localparam logic [BW-1:0]        BYTES_LINE = BW'(2 * H_ACTIVE);
    localparam logic [BW-1:0]        BYTES_SAT  = '1;

    cam_state_e state_q, state_d;

    logic                 vs_d, hs_d;
    logic                 vs_fall, vs_rise, hs_fall;
    logic [1:0]           mode_q;
    logic [7:0]           hi_q;
    logic                 phase_q;
    logic [CAM_PIXEL-1:0] pixel_q;
    logic [CAM_LINE-1:0]  line_q;
    logic [BW-1:0]        byte_q;
    logic                 frame_start, line_end, frame_end, capture;
    logic                 frame_done_d, wr_ok;
    logic [11:0]          pack_data;

    assign vs_fall = vs_d & ~ov7670_vs;
    assign vs_rise = ~vs_d & ov7670_vs;
    assign hs_fall = hs_d & ~ov7670_hs;

`ifdef CAM_DOWNSCALE_EN
    assign wr_ok = (pixel_q < PIX_MAX) && (line_q < LINE_MAX)
                && !pixel_q[0] && !line_q[0];
`else
    assign wr_ok = (pixel_q < PIX_MAX) && (line_q < LINE_MAX);
`endif

    cam_pixel_pack u_pack (
        .mode  (mode_q),
        .hi    (hi_q),
        .lo    (ov7670_data),
        .pixel (pack_data)
    );

    always_ff @(posedge ov7670_pclk or negedge reset_n) begin
        if (!reset_n)
            state_q <= SYNC;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        line_end    = 1'b0;
        frame_end   = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            SYNC: begin
                if (vs_fall) begin
                    state_d     = FRAME;
                    frame_start = 1'b1;
                end
            end
            FRAME: begin
                if (vs_rise) begin
                    state_d   = SYNC;
                    frame_end = 1'b1;
                end else if (ov7670_hs) begin
                    state_d = ACTIVE;
                    capture = 1'b1;
                end
            end
            ACTIVE: begin
                // A vs rise also closes the line being captured.
                if (vs_rise || hs_fall)
                    line_end = 1'b1;
                if (vs_rise) begin
                    state_d   = SYNC;
                    frame_end = 1'b1;
                end else if (hs_fall) begin
                    state_d = FRAME;
                end else begin
                    capture = 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase
        frame_done_d = frame_end && ((line_q != '0) || line_end);
    end

    always_ff @(posedge ov7670_pclk or negedge reset_n) begin
        if (!reset_n) begin
            vs_d         <= 1'b0;
            hs_d         <= 1'b0;
            mode_q       <= 2'd0;
            hi_q         <= 8'd0;
            phase_q      <= 1'b0;
            pixel_q      <= '0;
            line_q       <= '0;
            byte_q       <= '0;
            we           <= 1'b0;
            o_data_wr    <= '0;
            o_line       <= '0;
            o_pixel      <= '0;
            o_frame_done <= 1'b0;
            o_line_err   <= 1'b0;
        end else begin
            vs_d         <= ov7670_vs;
            hs_d         <= ov7670_hs;
            we           <= 1'b0;
            o_frame_done <= frame_done_d;
            if (frame_start) begin
                mode_q     <= norm_mode(i_mode);
                phase_q    <= 1'b0;
                pixel_q    <= '0;
                line_q     <= '0;
                byte_q     <= '0;
                o_line_err <= 1'b0;
            end
            if (line_end) begin
                if (line_q != LINE_MAX)
                    line_q <= line_q + 1'b1;
                phase_q <= 1'b0;
                pixel_q <= '0;
                byte_q  <= '0;
                if (byte_q != BYTES_LINE)
                    o_line_err <= 1'b1;
            end
            if (capture) begin
                if (byte_q != BYTES_SAT)
                    byte_q <= byte_q + 1'b1;
                phase_q <= ~phase_q;
                if (!phase_q) begin
                    hi_q <= ov7670_data;
                end else begin
                    if (pixel_q != PIX_MAX)
                        pixel_q <= pixel_q + 1'b1;
                    if (wr_ok) begin
                        we        <= 1'b1;
                        o_data_wr <= pack_data;
`ifdef CAM_DOWNSCALE_EN
                        o_line    <= line_q >> 1;
                        o_pixel   <= pixel_q >> 1;
`else
                        o_line    <= line_q;
                        o_pixel   <= pixel_q;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Scoreboard bench for cam_frame_capture on a tiny 4-pixel frame.
// Optional build macro: CAM_DOWNSCALE_EN (bench switches to 4x4 and decimation).
module tb_cam_frame_capture;

    localparam int H = 4;
`ifdef CAM_DOWNSCALE_EN
    localparam int V = 4;
`else
    localparam int V = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vs, hs;
    logic [7:0]  data;
    logic [1:0]  mode;
    logic        we;
    logic [11:0] o_data_wr;
    logic [8:0]  o_line;
    logic [9:0]  o_pixel;
    logic        o_frame_done;
    logic        o_line_err;

    cam_frame_capture #(
        .CAM_DATA_WIDTH (12),
        .CAM_LINE       (9),
        .CAM_PIXEL      (10),
        .H_ACTIVE       (H),
        .V_ACTIVE       (V)
    ) dut (
        .ov7670_pclk  (clk),
        .reset_n      (reset_n),
        .ov7670_vs    (vs),
        .ov7670_hs    (hs),
        .ov7670_data  (data),
        .i_mode       (mode),
        .we           (we),
        .o_data_wr    (o_data_wr),
        .o_line       (o_line),
        .o_pixel      (o_pixel),
        .o_frame_done (o_frame_done),
        .o_line_err   (o_line_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] d;
        logic [8:0]  l;
        logic [9:0]  p;
    } wr_t;

    wr_t        sb[$];
    wr_t        mon_w;
    int         checks = 0;
    int         errors = 0;
    int         fd_cnt = 0;
    int         fd_exp = 0;
    int         cur_line;
    int         lines_sent;
    logic       err_exp;
    logic [1:0] fmode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model_pix(input logic [1:0] m, input logic [7:0] h, input logic [7:0] l);
        logic [4:0] r5, b5;
        logic [5:0] g6;
        r5 = h[7:3];
        g6 = {h[2:0], l[7:5]};
        b5 = l[4:0];
        case (m)
            2'd1:    return {h[3:0], l[7:4], l[3:0]};
            2'd2:    return {l[7:4], l[7:4], l[7:4]};
            default: return {r5[4:1], g6[5:2], b5[4:1]};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int px, input logic [11:0] d);
        wr_t w;
        if (px < H && cur_line < V) begin
`ifdef CAM_DOWNSCALE_EN
            if (px % 2 == 0 && cur_line % 2 == 0) begin
                w.d = d;
                w.l = 9'(cur_line / 2);
                w.p = 10'(px / 2);
                sb.push_back(w);
            end
`else
            w.d = d;
            w.l = 9'(cur_line);
            w.p = 10'(px);
            sb.push_back(w);
`endif
        end
    endtask

    task automatic send_line(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input bit vs_end);
        logic [7:0] pat [4];
        logic [7:0] prev;
        pat  = '{b0, b1, b2, b3};
        prev = 8'd0;
        for (int k = 0; k < n; k++) begin
            hs   = 1'b1;
            data = pat[k % 4];
            if (k % 2 == 1)
                push_exp(k / 2, model_pix(fmode, prev, data));
            prev = data;
            tick();
        end
        hs = 1'b0;
        if (vs_end)
            vs = 1'b1;
        tick();
        if (n != 2 * H)
            err_exp = 1'b1;
        lines_sent++;
        if (cur_line < V)
            cur_line++;
        check("line_err", o_line_err, err_exp);
        tick();
    endtask

    task automatic start_frame(input logic [1:0] m);
        mode = m;
        vs   = 1'b1;
        hs   = 1'b0;
        tick();
        tick();
        vs = 1'b0;
        tick();
        err_exp    = 1'b0;
        fmode      = (m == 2'd3) ? 2'd0 : m;
        cur_line   = 0;
        lines_sent = 0;
        check("err_clear", o_line_err, err_exp);
        tick();
    endtask

    task automatic end_frame();
        if (!vs) begin
            vs = 1'b1;
            tick();
            check("frame_done_pulse", o_frame_done, lines_sent > 0);
            tick();
            check("frame_done_width", o_frame_done, 1'b0);
        end else begin
            tick();
        end
        if (lines_sent > 0)
            fd_exp++;
        check("frame_done_cnt", fd_cnt, fd_exp);
        check("sb_drained", sb.size(), 0);
        check("err_hold", o_line_err, err_exp);
    endtask

    always @(negedge clk) begin
        if (o_frame_done)
            fd_cnt++;
        if (reset_n && we) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", sb.size(), 1);
            end else begin
                mon_w = sb.pop_front();
                check("wr_data", o_data_wr, mon_w.d);
                check("wr_line", o_line, mon_w.l);
                check("wr_pixel", o_pixel, mon_w.p);
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        vs         = 1'b0;
        hs         = 1'b0;
        data       = 8'd0;
        mode       = 2'd0;
        err_exp    = 1'b0;
        fmode      = 2'd0;
        cur_line   = 0;
        lines_sent = 0;
        repeat (3) tick();
        check("rst_we", we, 1'b0);
        check("rst_data", o_data_wr, 12'd0);
        check("rst_line", o_line, 9'd0);
        check("rst_pixel", o_pixel, 10'd0);
        check("rst_fdone", o_frame_done, 1'b0);
        check("rst_lerr", o_line_err, 1'b0);

        // Released mid-frame: these lines must produce nothing.
        reset_n = 1'b1;
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 2 * H; k++) begin
                hs   = 1'b1;
                data = 8'(8'h40 + k);
                tick();
            end
            hs = 1'b0;
            tick();
            tick();
        end
        check("midframe_no_done", fd_cnt, 0);
        check("midframe_no_err", o_line_err, 1'b0);

        start_frame(2'd0);
        for (int l = 0; l < V; l++)
            send_line(2 * H, 8'hF8, 8'h00, 8'hF8, 8'h00, 1'b0);
        end_frame();

        start_frame(2'd2);
        mode = 2'd0;
        for (int l = 0; l < V; l++)
            send_line(2 * H, 8'h80, 8'hA5, 8'h80, 8'h3C, 1'b0);
        end_frame();

        start_frame(2'd1);
        for (int l = 0; l < V; l++)
            send_line(2 * H, 8'h0A, 8'hBC, 8'h05, 8'h3E, 1'b0);
        end_frame();

        start_frame(2'd3);
        for (int l = 0; l < V; l++)
            send_line(2 * H, 8'h7B, 8'hE4, 8'h12, 8'h9D, 1'b0);
        end_frame();

        start_frame(2'd0);
        send_line(7, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        for (int l = 1; l < V; l++)
            send_line(2 * H, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 1'b0);
        end_frame();

        start_frame(2'd1);
        send_line(10, 8'h01, 8'h23, 8'h45, 8'h67, 1'b0);
        for (int l = 1; l < V; l++)
            send_line(2 * H, 8'h89, 8'hAB, 8'hCD, 8'hEF, 1'b0);
        end_frame();

        start_frame(2'd1);
        for (int l = 0; l < V + 1; l++)
            send_line(2 * H, 8'h5A, 8'hC3, 8'hA5, 8'h3C, 1'b0);
        end_frame();

        start_frame(2'd0);
        for (int l = 0; l < V - 1; l++)
            send_line(2 * H, 8'hFF, 8'hFF, 8'h00, 8'h1F, 1'b0);
        send_line(2 * H, 8'hFF, 8'hFF, 8'h00, 8'h1F, 1'b1);
        end_frame();

        start_frame(2'd0);
        send_line(2 * H, 8'h07, 8'hE0, 8'hF8, 8'h1F, 1'b0);
        end_frame();

        start_frame(2'd2);
        end_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
